// File: rtl/jk_flop_bank_pkg.sv
// rtl/jk_flop_bank_pkg.sv - shared mode encoding for the multi-mode flip-flop bank
package jk_flop_bank_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      HOLD = 3'd0,
      JK   = 3'd1,
      SR   = 3'd2,
      D    = 3'd3,
      T    = 3'd4,
      SHL  = 3'd5,
      SHR  = 3'd6,
      CNT  = 3'd7
   } mode_e;

endpackage

// File: rtl/jk_flop_bank.sv
// rtl/jk_flop_bank.sv - WIDTH-bit register with JK/SR/D/T/shift/count update rules
module jk_flop_bank
   import jk_flop_bank_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  j,
   input  logic [WIDTH-1:0]  k,
   input  logic              ser_in,
   input  logic              clr_err,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qn,
   output logic              ser_out,
   output logic              wrap,
   output logic              err
);

   mode_e            mode_s;
   logic [WIDTH-1:0] q_q, q_d;
   logic             ser_out_q, ser_out_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] shl_w, shr_w;

   assign mode_s = mode_e'(mode);

   // A one-bit register shifts straight from ser_in in either direction
   if (WIDTH == 1) begin : g_shift_w1
      assign shl_w = ser_in;
      assign shr_w = ser_in;
   end else begin : g_shift_wn
      assign shl_w = {q_q[WIDTH-2:0], ser_in};
      assign shr_w = {ser_in, q_q[WIDTH-1:1]};
   end

   // Next-state selection over the update rule; illegal SR bits hold and raise err
   always_comb begin
      q_d       = q_q;
      ser_out_d = ser_out_q;
      wrap_d    = 1'b0;
      err_d     = clr_err ? 1'b0 : err_q;
      if (en) begin
         case (mode_s)
            HOLD: q_d = q_q;
            JK:   q_d = (j & ~q_q) | (~k & q_q);
            SR: begin
               q_d = (q_q | (j & ~k)) & ~(k & ~j);
               if (|(j & k)) begin
                  err_d = 1'b1;
               end
            end
            D:    q_d = j;
            T:    q_d = q_q ^ j;
            SHL: begin
               q_d       = shl_w;
               ser_out_d = q_q[WIDTH-1];
            end
            SHR: begin
               q_d       = shr_w;
               ser_out_d = q_q[0];
            end
            CNT: begin
               q_d    = q_q + WIDTH'(1);
               wrap_d = &q_q;
            end
            default: q_d = q_q;
         endcase
      end
   end

   // State register; reset asserts immediately and abandons any count or shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q       <= RESET_VALUE;
         ser_out_q <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         q_q       <= q_d;
         ser_out_q <= ser_out_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
      end
   end

   assign q       = q_q;
   assign qn      = ~q_q;
   assign ser_out = ser_out_q;
   assign wrap    = wrap_q;
   assign err     = err_q;

endmodule

// File: tb/tb_jk_flop_bank.sv
// tb/tb_jk_flop_bank.sv - scoreboard bench for an 8-bit and a 1-bit flip-flop bank
module tb_jk_flop_bank;
   import jk_flop_bank_pkg::*;

   typedef struct {
      bit         inst;
      logic [7:0] q;
      logic       so;
      logic       wr;
      logic       er;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              a_rst_n, a_en, a_ser, a_clr;
   logic [MODE_W-1:0] a_mode;
   logic [7:0]        a_j, a_k, a_q, a_qn;
   logic              a_so, a_wrap, a_err;

   logic              b_rst_n, b_en, b_ser, b_clr;
   logic [MODE_W-1:0] b_mode;
   logic [0:0]        b_j, b_k, b_q, b_qn;
   logic              b_so, b_wrap, b_err;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic async_req = 1'b0;

   jk_flop_bank #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_a (
      .clk(clk), .rst_n(a_rst_n), .en(a_en), .mode(a_mode), .j(a_j), .k(a_k),
      .ser_in(a_ser), .clr_err(a_clr), .q(a_q), .qn(a_qn), .ser_out(a_so),
      .wrap(a_wrap), .err(a_err)
   );

   jk_flop_bank #(.WIDTH(1), .RESET_VALUE(1'b0)) u_b (
      .clk(clk), .rst_n(b_rst_n), .en(b_en), .mode(b_mode), .j(b_j), .k(b_k),
      .ser_in(b_ser), .clr_err(b_clr), .q(b_q), .qn(b_qn), .ser_out(b_so),
      .wrap(b_wrap), .err(b_err)
   );

   // Monitor: after every rising edge, or after an asynchronous reset event, check queued expectations
   initial begin
      exp_t        e;
      logic [18:0] act, exp;
      forever begin
         @(posedge clk or posedge async_req);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 1'b0) begin
               act = {a_q, a_qn, a_so, a_wrap, a_err};
               exp = {e.q, ~e.q, e.so, e.wr, e.er};
            end else begin
               act = {7'b0, b_q, 7'b0, b_qn, b_so, b_wrap, b_err};
               exp = {7'b0, e.q[0], 7'b0, ~e.q[0], e.so, e.wr, e.er};
            end
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL %s: got q/qn/so/wrap/err=%h required %h", e.name, act, exp);
            end
         end
      end
   end

   task automatic drive(input bit inst, input mode_e m, input logic [7:0] jv, input logic [7:0] kv,
                        input logic ser, input logic clr, input logic env);
      if (inst == 1'b0) begin
         a_mode = m; a_j = jv; a_k = kv; a_ser = ser; a_clr = clr; a_en = env;
      end else begin
         b_mode = m; b_j = jv[0]; b_k = kv[0]; b_ser = ser; b_clr = clr; b_en = env;
      end
   endtask

   task automatic expect_now(input bit inst, input logic [7:0] eq, input logic eso,
                             input logic ewr, input logic eer, input string name);
      sb.push_back('{inst: inst, q: eq, so: eso, wr: ewr, er: eer, name: name});
   endtask

   task automatic step(input bit inst, input mode_e m, input logic [7:0] jv, input logic [7:0] kv,
                       input logic ser, input logic clr, input logic env,
                       input logic [7:0] eq, input logic eso, input logic ewr, input logic eer,
                       input string name);
      @(negedge clk);
      drive(inst, m, jv, kv, ser, clr, env);
      expect_now(inst, eq, eso, ewr, eer, name);
   endtask

   // Set up a counting update, then pull reset low between edges and check immediately
   task automatic mid_reset(input bit inst, input logic [7:0] rv, input string name);
      @(negedge clk);
      drive(inst, CNT, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      #2;
      if (inst == 1'b0) a_rst_n = 1'b0; else b_rst_n = 1'b0;
      expect_now(inst, rv, 1'b0, 1'b0, 1'b0, {name, "_async"});
      async_req = 1'b1;
      #1 async_req = 1'b0;
      @(negedge clk);
      expect_now(inst, rv, 1'b0, 1'b0, 1'b0, {name, "_held"});
      @(negedge clk);
      if (inst == 1'b0) a_rst_n = 1'b1; else b_rst_n = 1'b1;
      drive(inst, HOLD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      expect_now(inst, rv, 1'b0, 1'b0, 1'b0, {name, "_release"});
   endtask

   initial begin
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      drive(1'b0, HOLD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, HOLD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      expect_now(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, "a_reset");
      expect_now(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "b_reset");
      async_req = 1'b1;
      #1 async_req = 1'b0;
      @(negedge clk);
      a_rst_n = 1'b1; b_rst_n = 1'b1;

      // 8-bit instance: inst, mode, j, k, ser, clr, en -> q, ser_out, wrap, err
      step(0, HOLD, 8'h00, 8'h00, 0, 0, 0, 8'hA5, 0, 0, 0, "a_hold_after_reset");
      step(0, T,    8'h3C, 8'h00, 0, 0, 1, 8'h99, 0, 0, 0, "a_t_toggle");
      step(0, D,    8'hF0, 8'hFF, 0, 0, 1, 8'hF0, 0, 0, 0, "a_d_load");
      step(0, JK,   8'hCC, 8'hAA, 0, 0, 1, 8'h5C, 0, 0, 0, "a_jk");
      for (int i = 0; i < 3; i++)
         step(0, JK, 8'hCC, 8'hAA, 0, 0, 0, 8'h5C, 0, 0, 0, "a_jk_en0");
      step(0, D,    8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, "a_d_zero");
      step(0, SR,   8'h81, 8'h01, 0, 0, 1, 8'h80, 0, 0, 1, "a_sr_illegal");
      step(0, SR,   8'h01, 8'h01, 0, 1, 1, 8'h80, 0, 0, 1, "a_sr_set_beats_clr");
      step(0, HOLD, 8'h00, 8'h00, 0, 1, 1, 8'h80, 0, 0, 0, "a_clr_err");
      step(0, SR,   8'h01, 8'h01, 0, 0, 0, 8'h80, 0, 0, 0, "a_sr_en0_no_err");
      step(0, SR,   8'h01, 8'h01, 0, 0, 1, 8'h80, 0, 0, 1, "a_sr_err_again");
      step(0, HOLD, 8'h00, 8'h00, 0, 1, 0, 8'h80, 0, 0, 0, "a_clr_while_en0");
      step(0, D,    8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, "a_d_zero2");
      step(0, SHL,  8'h00, 8'h00, 1, 0, 1, 8'h01, 0, 0, 0, "a_shl1");
      step(0, SHL,  8'h00, 8'h00, 1, 0, 1, 8'h03, 0, 0, 0, "a_shl2");
      step(0, SHL,  8'h00, 8'h00, 1, 0, 1, 8'h07, 0, 0, 0, "a_shl3");
      step(0, SHL,  8'h00, 8'h00, 1, 0, 1, 8'h0F, 0, 0, 0, "a_shl4");
      step(0, SHL,  8'h00, 8'h00, 1, 0, 1, 8'h1F, 0, 0, 0, "a_shl5");
      step(0, SHL,  8'h00, 8'h00, 1, 0, 1, 8'h3F, 0, 0, 0, "a_shl6");
      step(0, SHL,  8'h00, 8'h00, 1, 0, 1, 8'h7F, 0, 0, 0, "a_shl7");
      step(0, SHL,  8'h00, 8'h00, 1, 0, 1, 8'hFF, 0, 0, 0, "a_shl8");
      step(0, SHR,  8'h00, 8'h00, 0, 0, 1, 8'h7F, 1, 0, 0, "a_shr");
      step(0, D,    8'hFE, 8'h00, 0, 0, 1, 8'hFE, 1, 0, 0, "a_d_so_holds");
      step(0, CNT,  8'h00, 8'h00, 0, 0, 1, 8'hFF, 1, 0, 0, "a_cnt_ff");
      step(0, CNT,  8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 1, 0, "a_cnt_wrap");
      step(0, CNT,  8'h00, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, "a_cnt_01");
      step(0, D,    8'hFF, 8'h00, 0, 0, 1, 8'hFF, 1, 0, 0, "a_d_ff");
      step(0, CNT,  8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 1, 0, "a_cnt_wrap2");
      step(0, HOLD, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, "a_wrap_drops_en0");
      step(0, D,    8'hFF, 8'h00, 0, 0, 1, 8'hFF, 1, 0, 0, "a_d_ff2");
      mid_reset(0, 8'hA5, "a_midcnt_reset");

      // 1-bit instance
      step(1, HOLD, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "b_hold");
      step(1, T,    8'h01, 8'h00, 0, 0, 1, 8'h01, 0, 0, 0, "b_t1");
      step(1, T,    8'h01, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, "b_t2");
      step(1, T,    8'h01, 8'h00, 0, 0, 1, 8'h01, 0, 0, 0, "b_t3");
      step(1, SHL,  8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, "b_shl0");
      step(1, SHL,  8'h00, 8'h00, 1, 0, 1, 8'h01, 0, 0, 0, "b_shl1");
      step(1, SHR,  8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, "b_shr0");
      step(1, CNT,  8'h00, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, "b_cnt1");
      step(1, CNT,  8'h00, 8'h00, 0, 0, 1, 8'h00, 1, 1, 0, "b_cnt_wrap");
      step(1, CNT,  8'h00, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, "b_cnt_again");
      mid_reset(1, 8'h00, "b_midcnt_reset");

      // Bounded drain of anything still queued
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
